md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit.sv | 120 ++++++++++++
 tb/tb_md_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO result registers and a fixed-latency busy window.
// Optional build macro MDU_DIV0_KEEP_EN: a divide by zero leaves HI/LO untouched.
module md_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        IntReq,
    output logic        busy,
    output logic [31:0] MDout
);
    typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} md_op_e;

    localparam logic [3:0] MUL_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;

    logic [31:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    md_op_e      op_q, op_d;

    // Datapath works from the captured operands only.
    logic        mul_sgn, div_sgn, a_neg, b_neg;
    logic [63:0] a_ext, b_ext, prod;
    logic [31:0] a_mag, b_mag, b_safe, uq, ur, quo, rem;

    always_comb begin
        mul_sgn = (op_q == OP_MULT);
        a_ext   = {mul_sgn ? {32{a_q[31]}} : 32'd0, a_q};
        b_ext   = {mul_sgn ? {32{b_q[31]}} : 32'd0, b_q};
        prod    = a_ext * b_ext;

        // Signed divide via magnitudes; 0x8000_0000 / -1 falls out as 0x8000_0000 rem 0.
        div_sgn = (op_q == OP_DIV);
        a_neg   = div_sgn & a_q[31];
        b_neg   = div_sgn & b_q[31];
        a_mag   = a_neg ? -a_q : a_q;
        b_mag   = b_neg ? -b_q : b_q;
        b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
        uq      = a_mag / b_safe;
        ur      = a_mag % b_safe;
        quo     = (a_neg ^ b_neg) ? -uq : uq;
        rem     = a_neg ? -ur : ur;
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (busy_q) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                busy_d = 1'b0;
                if (op_q == OP_MULT || op_q == OP_MULTU) begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end else if (b_q == 32'd0) begin
`ifdef MDU_DIV0_KEEP_EN
                    hi_d = hi_q;
                    lo_d = lo_q;
`else
                    hi_d = a_q;
                    lo_d = 32'hFFFF_FFFF;
`endif
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
        end else if (start && !IntReq) begin
            case (MDop)
                4'd1, 4'd2, 4'd3, 4'd4: begin
                    a_d    = A;
                    b_d    = B;
                    busy_d = 1'b1;
                    cnt_d  = (MDop <= 4'd2) ? MUL_CYCLES : DIV_CYCLES;
                    case (MDop)
                        4'd1:    op_d = OP_MULT;
                        4'd2:    op_d = OP_MULTU;
                        4'd3:    op_d = OP_DIV;
                        default: op_d = OP_DIVU;
                    endcase
                end
                4'd7:    hi_d = A;
                4'd8:    lo_d = A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            op_q   <= OP_MULT;
            cnt_q  <= 4'd0;
            busy_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy  = busy_q;
    assign MDout = (MDop == 4'd5) ? hi_q :
                   (MDop == 4'd6) ? lo_q : 32'd0;
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latencies, HI/LO results, flush and reset behaviour.
module tb_md_unit;
    logic        clk = 1'b0;
    logic        reset, start, IntReq;
    logic [3:0]  MDop;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] MDout;
    int          checks = 0;
    int          errors = 0;

    md_unit dut (
        .clk(clk), .reset(reset), .start(start), .MDop(MDop), .A(A), .B(B),
        .IntReq(IntReq), .busy(busy), .MDout(MDout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called in the negedge phase; combinational read settles within 1ns.
    task automatic rd(input logic [3:0] op, input string tag, input logic [31:0] exp);
        MDop = op;
        #1;
        chk(tag, MDout, exp);
        MDop = 4'd0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic irq);
        start = 1'b1; MDop = op; A = a; B = b; IntReq = irq;
        @(posedge clk); #1;
        start = 1'b0; MDop = 4'd0; IntReq = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int len,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        issue(op, a, b, 1'b0);
        wait_idle(n);
        chk({tag, "_len"}, n, len);
        rd(4'd5, {tag, "_hi"}, ehi);
        rd(4'd6, {tag, "_lo"}, elo);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, highs;
        reset = 1'b1; start = 1'b0; IntReq = 1'b0; MDop = 4'd0; A = '0; B = '0;
        #2;
        chk("rst_busy", busy, 1'b0);
        rd(4'd5, "rst_hi", 32'd0);
        rd(4'd6, "rst_lo", 32'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);

        run_op("mult", 4'd1, -32'sd3, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div", 4'd3, -32'sd7, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`ifdef MDU_DIV0_KEEP_EN
        run_op("divu0", 4'd4, 32'd5, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
        run_op("divu0", 4'd4, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF);
`endif

        issue(4'd7, 32'h1111, 32'd0, 1'b0);
        chk("mthi_busy", busy, 1'b0);
        issue(4'd8, 32'h2222, 32'd0, 1'b0);
        rd(4'd5, "mthi", 32'h1111);
        rd(4'd6, "mtlo", 32'h2222);
        @(negedge clk);
        issue(4'd2, 32'd3, 32'd4, 1'b1);
        chk("flush_busy", busy, 1'b0);
        issue(4'd8, 32'd1234, 32'd0, 1'b1);
        rd(4'd5, "flush_hi", 32'h1111);
        rd(4'd6, "flush_lo", 32'h2222);
        rd(4'd7, "rd_op7", 32'd0);
        rd(4'd0, "rd_op0", 32'd0);
        @(negedge clk);
        rd(4'd15, "rd_op15", 32'd0);
        @(negedge clk);

        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'd1, 32'hFFFF_FFFE);
        run_op("mults", 4'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
        run_op("divneg", 4'd3, 32'd7, -32'sd2, 10, 32'd1, 32'hFFFF_FFFD);

        // Div in flight: a mult start is dropped, IntReq mid-flight is harmless, reads see old LO.
        issue(4'd3, 32'd100, 32'd7, 1'b0);
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 2) begin
                start = 1'b1; MDop = 4'd1; A = 32'd3; B = 32'd4;
                @(posedge clk); #1;
                start = 1'b0; MDop = 4'd0;
            end else if (n == 4) begin
                IntReq = 1'b1;
            end else if (n == 5) begin
                rd(4'd6, "busy_old_lo", 32'hFFFF_FFFD);
            end
            @(negedge clk);
        end
        IntReq = 1'b0;
        chk("stall_len", n, 10);
        rd(4'd5, "stall_hi", 32'd2);
        rd(4'd6, "stall_lo", 32'd14);
        @(negedge clk);
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) highs++;
            @(negedge clk);
        end
        chk("busy_once", highs, 0);

        // Reset asserted in the third cycle of a div.
        issue(4'd3, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        rd(4'd5, "mid_rst_hi", 32'd0);
        rd(4'd6, "mid_rst_lo", 32'd0);
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 12; i++) @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);
        rd(4'd5, "post_rst_hi", 32'd0);
        rd(4'd6, "post_rst_lo", 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
